// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Produces the ciphertext and the round-10 key, which is the cipherkey input the decrypt
// core needs to recover the plaintext and the original key.
module aes128_encrypt_iter #(
    parameter int unsigned NR = 10  // only 10 is legal
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plain_text,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher_text,
    output logic [127:0] last_key
);

    typedef enum logic [0:0] {StIdle, StRun} fsm_e;

    localparam logic [3:0] LastRnd = 4'(NR);

    // FIPS-197 S-box, row-major; entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SboxTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8x == {~x, 3'b111}
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTbl[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        rc = 8'h00;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One MixColumns column: rows of the fixed matrix {02 03 01 01} rotated.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] lk_q, lk_d;

    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [127:0] next_key;
    logic [127:0] sub_v;
    logic [127:0] shr_v;
    logic [127:0] mix_v;

    // Key schedule: derive the next round key from the current one (four key S-boxes).
    always_comb begin
        rot_w    = {rkey_q[23:0], rkey_q[31:24]};
        sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        next_key = '0;
        next_key[127:96] = rkey_q[127:96] ^ sub_w ^ {rcon(rnd_q), 24'h000000};
        next_key[95:64]  = rkey_q[95:64] ^ next_key[127:96];
        next_key[63:32]  = rkey_q[63:32] ^ next_key[95:64];
        next_key[31:0]   = rkey_q[31:0]  ^ next_key[63:32];
    end

    // Round datapath: SubBytes (sixteen S-boxes), ShiftRows, MixColumns.
    always_comb begin
        sub_v = '0;
        shr_v = '0;
        mix_v = '0;
        for (int i = 0; i < 16; i++) begin
            sub_v[127 - 8 * i -: 8] = sbox(state_q[127 - 8 * i -: 8]);
        end
        // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
        for (int i = 0; i < 16; i++) begin
            shr_v[127 - 8 * i -: 8] =
                sub_v[127 - 8 * ((i % 4) + 4 * (((i / 4) + (i % 4)) % 4)) -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mix_v[127 - 32 * c -: 32] = mix_col(shr_v[127 - 32 * c -: 32]);
        end
    end

    // Control FSM and next-state selection for all registers.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        ct_d    = ct_q;
        lk_d    = lk_q;
        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    state_d = plain_text ^ cipher_key;
                    rkey_d  = cipher_key;
                    rnd_d   = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                rkey_d = next_key;
                if (rnd_q == LastRnd) begin
                    // Final round skips MixColumns; counter stays put so it never passes 10.
                    ct_d   = shr_v ^ next_key;
                    lk_d   = next_key;
                    done_d = 1'b1;
                    fsm_d  = StIdle;
                end else begin
                    state_d = mix_v ^ next_key;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
            ct_q    <= '0;
            lk_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
            lk_q    <= lk_d;
        end
    end

    assign busy        = (fsm_q == StRun);
    assign done        = done_q;
    assign cipher_text = ct_q;
    assign last_key    = lk_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter: known FIPS vectors plus random blocks checked
// against a byte-array AES model; every result is also decrypted from (cipher_text, last_key).
module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] plain_text = '0;
    logic [127:0] cipher_key = '0;
    logic         busy;
    logic         done;
    logic [127:0] cipher_text;
    logic [127:0] last_key;

    aes128_encrypt_iter #(.NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .plain_text  (plain_text),
        .cipher_key  (cipher_key),
        .busy        (busy),
        .done        (done),
        .cipher_text (cipher_text),
        .last_key    (last_key)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] lk;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from the definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [7:0] rc_of(input int j);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < j; k++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // Source index of ShiftRows: out byte i (row i%4, col i/4) comes from col (c+r)%4.
    function automatic int shr_src(input int i);
        return (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
    endfunction

    // Returns {ciphertext, w[40..43]}.
    function automatic logic [255:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc_of(i / 4), 24'h0};
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[shr_src(i)]];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r < 10)
                        s[4 * c + j] = gmul(8'h02, t[4 * c + j]) ^ gmul(8'h03, t[4 * c + (j + 1) % 4])
                                     ^ t[4 * c + (j + 2) % 4] ^ t[4 * c + (j + 3) % 4];
                    else
                        s[4 * c + j] = t[4 * c + j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        return {ct, w[40], w[41], w[42], w[43]};
    endfunction

    // Inverse cipher starting from the round-10 key; returns {plaintext, original key}.
    function automatic logic [255:0] model_dec(input logic [127:0] ct, input logic [127:0] lk);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [127:0] pt;
        for (int i = 0; i < 4; i++) w[40 + i] = lk[127 - 32 * i -: 32];
        for (int i = 39; i >= 0; i--) begin
            tmp = w[i + 3];
            if ((i + 4) % 4 == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc_of((i + 4) / 4), 24'h0};
            w[i] = w[i + 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8 * i -: 8] ^ w[40 + i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) t[shr_src(i)] = isb[s[i]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r > 0)
                        s[4 * c + j] = gmul(8'h0e, t[4 * c + j]) ^ gmul(8'h0b, t[4 * c + (j + 1) % 4])
                                     ^ gmul(8'h0d, t[4 * c + (j + 2) % 4])
                                     ^ gmul(8'h09, t[4 * c + (j + 3) % 4]);
                    else
                        s[4 * c + j] = t[4 * c + j];
                end
            end
        end
        for (int i = 0; i < 16; i++) pt[127 - 8 * i -: 8] = s[i];
        return {pt, w[0], w[1], w[2], w[3]};
    endfunction

    // ---------------- monitor ----------------
    exp_t         mon_e;
    logic [255:0] mon_dec;

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("cipher_text", cipher_text, mon_e.ct);
                check("last_key", last_key, mon_e.lk);
                check("done_cycle", 128'(cyc), 128'(mon_e.cyc));
                check("busy_in_done", 128'(busy), 128'(0));
                mon_dec = model_dec(cipher_text, last_key);
                check("loopback_pt", mon_dec[255:128], mon_e.pt);
                check("loopback_key", mon_dec[127:0], mon_e.key);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called #1 after a clock edge; the block is sampled at the next edge.
    task automatic issue(input logic [127:0] pt, input logic [127:0] key,
                         input bit known, input logic [127:0] kct, input logic [127:0] klk);
        exp_t e;
        logic [255:0] m;
        e.pt  = pt;
        e.key = key;
        if (known) begin
            e.ct = kct;
            e.lk = klk;
        end else begin
            m    = model_enc(pt, key);
            e.ct = m[255:128];
            e.lk = m[127:0];
        end
        e.cyc = cyc + 11;
        exp_q.push_back(e);
        start      = 1'b1;
        plain_text = pt;
        cipher_key = key;
        @(posedge clk);
        #1;
        start      = 1'b0;
        plain_text = rand128();
        cipher_key = rand128();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
        end
    endtask

    localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LkB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LkC  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_cipher_text", cipher_text, '0);
        check("reset_last_key", last_key, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS B, then FIPS C.1 launched in the done cycle of the first.
        issue(PtB, KeyB, 1'b1, CtB, LkB);
        wait_idle();
        issue(PtC, KeyC, 1'b1, CtC, LkC);
        wait_idle();

        // Start pulses and input churn while busy must be ignored.
        @(posedge clk);
        #1;
        issue(PtB, KeyB, 1'b1, CtB, LkB);
        for (int k = 0; k < 8; k++) begin
            start      = 1'($urandom);
            plain_text = rand128();
            cipher_key = rand128();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("held_cipher_text", cipher_text, CtB);
        check("held_last_key", last_key, LkB);

        // Reset mid-run: silent abort, outputs cleared.
        issue(PtC, KeyC, 1'b1, CtC, LkC);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_cipher_text", cipher_text, '0);
        check("abort_last_key", last_key, '0);
        issue(PtC, KeyC, 1'b1, CtC, LkC);
        wait_idle();

        // Random blocks, back-to-back.
        for (int i = 0; i < 500; i++) begin
            issue(rand128(), rand128(), 1'b0, '0, '0);
            wait_idle();
        end

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("pending_results", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
